// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer
// Iterative signed multiply/divide unit that sits beside the register bank and
// feeds the HI/LO registers. A one-cycle start with an opcode launches either a
// Booth radix-2 multiply or a restoring divide on operand magnitudes; each runs
// for exactly WIDTH iterations, then a single DONE cycle presents the result and
// pulses the HI/LO write enables. A divide by zero is reported through a
// one-cycle div_zero pulse instead.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-low reset
//   start     one-cycle request, sampled only while idle
//   op        01 = mult, 10 = div, 00/11 = no operation
//   a_in      rs operand (multiplicand / dividend)
//   b_in      rt operand (multiplier / divisor)
//   busy      high from the cycle after an accepted start through DONE/DZERO
//   done      one-cycle pulse, hi_out/lo_out hold the new result
//   div_zero  one-cycle pulse, divide requested with b_in == 0
//   hi_out    mult: upper product half, div: remainder
//   lo_out    mult: lower product half, div: quotient
//   hi_write  HI register load enable (same as done)
//   lo_write  LO register load enable (same as done)
module multdiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             hi_write,
  output logic             lo_write
);

  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MULT  = 3'd1,
    DIV   = 3'd2,
    DONE  = 3'd3,
    DZERO = 3'd4
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic               q_m1;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   hi_hold;
  logic [WIDTH-1:0]   lo_hold;
  logic [WIDTH-1:0]   hi_res;
  logic [WIDTH-1:0]   lo_res;
  logic [WIDTH:0]     booth_sum;
  logic [WIDTH-1:0]   div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
  logic               last_iter;

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // State register for the sequencing FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the status/enable outputs, which are pure decodes
  // of the registered state. During DONE the result is shown through the
  // sign fix-up path; otherwise the last committed result is held.
  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    div_zero   = 1'b0;
    hi_out     = hi_hold;
    lo_out     = lo_hold;
    case (state)
      IDLE: begin
        if (start && op == OP_MULT) begin
          next_state = MULT;
        end else if (start && op == OP_DIV) begin
          next_state = (b_in == '0) ? DZERO : DIV;
        end
      end
      MULT, DIV: begin
        if (last_iter) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        hi_out     = hi_res;
        lo_out     = lo_res;
        next_state = IDLE;
      end
      DZERO: begin
        div_zero   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    hi_write = done;
    lo_write = done;
  end

  // Iteration arithmetic. The Booth adder is one bit wider than the operands
  // so the arithmetic right shift keeps the true sign even when the add
  // overflows (e.g. most-negative times most-negative). In the divider the
  // partial remainder is always below the divisor magnitude (at most 2^(W-1)),
  // so its top bit is zero and the shifted remainder fits in WIDTH bits.
  // Sign fix-up: quotient negated when operand signs differ, remainder follows
  // the dividend.
  always_comb begin
    booth_sum = {acc_hi[WIDTH-1], acc_hi};
    case ({acc_lo[0], q_m1})
      2'b01:   booth_sum = {acc_hi[WIDTH-1], acc_hi} + {mcand[WIDTH-1], mcand};
      2'b10:   booth_sum = {acc_hi[WIDTH-1], acc_hi} - {mcand[WIDTH-1], mcand};
      default: booth_sum = {acc_hi[WIDTH-1], acc_hi};
    endcase
    div_shift = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {1'b0, mcand};
    div_ok    = ~div_diff[WIDTH];
    hi_res    = acc_hi;
    lo_res    = acc_lo;
    if (is_div) begin
      hi_res = neg_r ? ('0 - acc_hi) : acc_hi;
      lo_res = neg_q ? ('0 - acc_lo) : acc_lo;
    end
  end

  // Operand latching, iteration steps and result commit. Operands are only
  // captured on an accepted start in IDLE, so later starts or input changes
  // cannot disturb a running operation. The held result is committed on the
  // DONE-to-IDLE edge so it matches what was shown during DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      q_m1    <= 1'b0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      hi_hold <= '0;
      lo_hold <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && op == OP_MULT) begin
            cnt    <= '0;
            mcand  <= a_in;
            acc_hi <= '0;
            acc_lo <= b_in;
            q_m1   <= 1'b0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
          end else if (start && op == OP_DIV && b_in != '0) begin
            cnt    <= '0;
            mcand  <= b_in[WIDTH-1] ? ('0 - b_in) : b_in;
            acc_hi <= '0;
            acc_lo <= a_in[WIDTH-1] ? ('0 - a_in) : a_in;
            q_m1   <= 1'b0;
            is_div <= 1'b1;
            neg_q  <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
            neg_r  <= a_in[WIDTH-1];
          end
        end
        MULT: begin
          acc_hi <= booth_sum[WIDTH:1];
          acc_lo <= {booth_sum[0], acc_lo[WIDTH-1:1]};
          q_m1   <= acc_lo[0];
          cnt    <= cnt + CNT_W'(1);
        end
        DIV: begin
          acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift;
          acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
          cnt    <= cnt + CNT_W'(1);
        end
        DONE: begin
          hi_hold <= hi_res;
          lo_hold <= lo_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer
// Directed bench for multdiv_sequencer. Each operation pushes its expected
// HI/LO pair (from a 64-bit signed arithmetic model) into a scoreboard queue;
// the entry is popped and compared when the DUT raises done or div_zero.
// Control outputs are compared cycle by cycle against the expected timeline.
module tb_multdiv_sequencer;

  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [1:0]        op;
  logic [WIDTH-1:0]  a_in;
  logic [WIDTH-1:0]  b_in;
  logic              busy;
  logic              done;
  logic              div_zero;
  logic [WIDTH-1:0]  hi_out;
  logic [WIDTH-1:0]  lo_out;
  logic              hi_write;
  logic              lo_write;

  typedef struct {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } exp_t;

  exp_t              expQ[$];
  int                testCount = 0;
  int                failCount = 0;
  logic [WIDTH-1:0]  heldHi = '0;
  logic [WIDTH-1:0]  heldLo = '0;

  multdiv_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .hi_write (hi_write),
    .lo_write (lo_write)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Single comparison point: counts the test and reports any failure.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: signed 64-bit arithmetic; SV division truncates toward
  // zero and the remainder follows the dividend.
  task automatic pushExpected(input logic [1:0] o, input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b);
    exp_t   e;
    longint sa;
    longint sb;
    longint p;
    longint q;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 2'b01) begin
      p    = sa * sb;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == '0) begin
      e.hi = heldHi;
      e.lo = heldLo;
    end else begin
      q    = sa / sb;
      r    = sa % sb;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    heldHi = e.hi;
    heldLo = e.lo;
    expQ.push_back(e);
  endtask

  // Drive a one-cycle start, then scramble the operand inputs.
  task automatic applyStimulus(input logic [1:0] o, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b);
    start = 1'b1;
    op    = o;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    a_in  = $urandom;
    b_in  = $urandom;
  endtask

  // Issue one operation and follow it to the following IDLE cycle.
  // interfereAt > 0 fires an extra div-by-zero start during that busy cycle.
  task automatic runOp(input string name, input logic [1:0] o,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int interfereAt);
    bit   isDz;
    int   last;
    int   resultAt;
    exp_t e;
    isDz     = (o == 2'b10 && b == '0);
    last     = isDz ? 2 : WIDTH + 2;
    resultAt = isDz ? 1 : WIDTH + 1;
    pushExpected(o, a, b);
    applyStimulus(o, a, b);
    for (int k = 1; k <= last; k++) begin
      logic [4:0] expCtl;
      if (isDz) begin
        expCtl = (k == 1) ? 5'b10100 : 5'b00000;
      end else if (k == WIDTH + 1) begin
        expCtl = 5'b11011;
      end else begin
        expCtl = (k <= WIDTH + 1) ? 5'b10000 : 5'b00000;
      end
      checkOutput($sformatf("%s ctl k=%0d", name, k),
                  {59'd0, busy, done, div_zero, hi_write, lo_write}, {59'd0, expCtl});
      if (k == resultAt) begin
        if (expQ.size() == 0) begin
          testCount++;
          failCount++;
          $error("[TB] FAIL %s scoreboard observed=empty expected=entry", name);
        end else begin
          e = expQ.pop_front();
          checkOutput({name, " hi"}, {32'd0, hi_out}, {32'd0, e.hi});
          checkOutput({name, " lo"}, {32'd0, lo_out}, {32'd0, e.lo});
        end
      end
      if (k == last) begin
        checkOutput({name, " hi held"}, {32'd0, hi_out}, {32'd0, heldHi});
        checkOutput({name, " lo held"}, {32'd0, lo_out}, {32'd0, heldLo});
      end else begin
        if (k == interfereAt) begin
          start = 1'b1;
          op    = 2'b10;
          a_in  = 32'd9;
          b_in  = 32'd0;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
  endtask

  // Directed sequence.
  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    int               donesSeen;
    reset = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a_in  = '0;
    b_in  = '0;
    #2;
    checkOutput("reset ctl", {59'd0, busy, done, div_zero, hi_write, lo_write}, 64'd0);
    checkOutput("reset hi", {32'd0, hi_out}, 64'd0);
    checkOutput("reset lo", {32'd0, lo_out}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    runOp("mult 7x-3", 2'b01, 32'd7, 32'hFFFFFFFD, 0);
    checkOutput("mult 7x-3 const", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFEB);
    runOp("mult min x min b2b", 2'b01, 32'h80000000, 32'h80000000, 0);
    checkOutput("mult min x min const", {hi_out, lo_out}, 64'h40000000_00000000);
    runOp("mult -1x-1 interfere", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5);
    checkOutput("mult -1x-1 const", {hi_out, lo_out}, 64'h00000000_00000001);
    runOp("div -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 0);
    checkOutput("div -7/2 const", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFFD);
    runOp("div 7/-2", 2'b10, 32'd7, 32'hFFFFFFFE, 0);
    checkOutput("div 7/-2 const", {hi_out, lo_out}, 64'h00000001_FFFFFFFD);
    runOp("div min/-1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
    checkOutput("div min/-1 const", {hi_out, lo_out}, 64'h00000000_80000000);
    runOp("mult 3x5", 2'b01, 32'd3, 32'd5, 0);
    runOp("div 9/0", 2'b10, 32'd9, 32'd0, 0);
    checkOutput("div 9/0 held", {hi_out, lo_out}, 64'h00000000_0000000F);

    start = 1'b1;
    op    = 2'b00;
    a_in  = 32'd4;
    b_in  = 32'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      checkOutput($sformatf("op00 ignored busy k=%0d", k), {63'd0, busy}, 64'd0);
      @(posedge clk);
      #1;
    end
    checkOutput("op00 ignored hi/lo", {hi_out, lo_out}, {heldHi, heldLo});

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (rb == '0) rb = 32'd1;
      runOp($sformatf("rand %0d", i), (i % 2 == 0) ? 2'b01 : 2'b10, ra, rb, 0);
    end

    applyStimulus(2'b10, 32'd100, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    #1;
    heldHi = '0;
    heldLo = '0;
    checkOutput("abort ctl", {59'd0, busy, done, div_zero, hi_write, lo_write}, 64'd0);
    checkOutput("abort hi/lo", {hi_out, lo_out}, 64'd0);
    donesSeen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) reset = 1'b1;
      if (done || hi_write || lo_write) donesSeen++;
    end
    checkOutput("abort no done", 64'(donesSeen), 64'd0);
    checkOutput("abort idle busy", {63'd0, busy}, 64'd0);
    runOp("mult 2x3 after abort", 2'b01, 32'd2, 32'd3, 0);
    checkOutput("mult 2x3 lo", {32'd0, lo_out}, 64'd6);
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
